// File: rtl/muldiv_pkg.sv
// Shared types and constants for the iterative multiply/divide unit.
package muldiv_pkg;

  typedef enum logic [1:0] {
    MD_MULT  = 2'b00,
    MD_MULTU = 2'b01,
    MD_DIV   = 2'b10,
    MD_DIVU  = 2'b11
  } md_op_e;

  typedef enum logic [2:0] {IDLE, PREP, CALC, FIX, DONE} md_state_e;

  // Most-negative two's-complement value of a given width (up to 64 bits).
  function automatic logic [63:0] md_most_neg(input int width);
    return 64'(1) << (width - 1);
  endfunction

endpackage

// File: rtl/muldiv_negate.sv
// Pass-through or two's-complement negation, selected by i_neg.
module muldiv_negate #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] i_x,
  input  logic             i_neg,
  output logic [WIDTH-1:0] o_y
);
  assign o_y = i_neg ? (~i_x + WIDTH'(1)) : i_x;
endmodule

// File: rtl/muldiv_seq.sv
// Iterative signed/unsigned MULT/DIV with internal HI/LO; one result bit per cycle.
module muldiv_seq
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  md_state_e          r_state, w_state_nxt;
  md_op_e             r_op;
  logic [WIDTH-1:0]   r_a, r_b, r_m, r_hi, r_lo;
  logic [2*WIDTH-1:0] r_acc;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_neg_res, r_neg_rem, r_div_zero;

  logic               w_is_div, w_signed;
  logic [WIDTH-1:0]   w_mag_a, w_mag_b, w_quo, w_rem, w_tsub;
  logic [2*WIDTH-1:0] w_prod, w_acc_mul, w_acc_div;
  logic [WIDTH:0]     w_msum, w_trial;
  logic               w_ge;

  assign w_is_div = (r_op == MD_DIV) || (r_op == MD_DIVU);
  assign w_signed = (r_op == MD_MULT) || (r_op == MD_DIV);

  muldiv_negate #(.WIDTH(WIDTH)) u_neg_a (
    .i_x(r_a), .i_neg(w_signed & r_a[WIDTH-1]), .o_y(w_mag_a));
  muldiv_negate #(.WIDTH(WIDTH)) u_neg_b (
    .i_x(r_b), .i_neg(w_signed & r_b[WIDTH-1]), .o_y(w_mag_b));
  muldiv_negate #(.WIDTH(2*WIDTH)) u_neg_p (
    .i_x(r_acc), .i_neg(r_neg_res), .o_y(w_prod));
  muldiv_negate #(.WIDTH(WIDTH)) u_neg_q (
    .i_x(r_acc[WIDTH-1:0]), .i_neg(r_neg_res), .o_y(w_quo));
  muldiv_negate #(.WIDTH(WIDTH)) u_neg_r (
    .i_x(r_acc[2*WIDTH-1:WIDTH]), .i_neg(r_neg_rem), .o_y(w_rem));

  // Shift-add: acc = {partial product, remaining multiplier bits}.
  assign w_msum    = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + {1'b0, (r_acc[0] ? r_m : '0)};
  assign w_acc_mul = {w_msum, r_acc[WIDTH-1:1]};

  // Restoring divide: acc = {remainder, dividend bits shifting into quotient}.
  assign w_trial   = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]};
  assign w_ge      = (w_trial >= {1'b0, r_m});
  assign w_tsub    = w_trial[WIDTH-1:0] - r_m;
  assign w_acc_div = {(w_ge ? w_tsub : w_trial[WIDTH-1:0]), r_acc[WIDTH-2:0], w_ge};

  always_comb begin
    w_state_nxt = r_state;
    busy        = 1'b0;
    done        = 1'b0;
    case (r_state)
      IDLE: w_state_nxt = start ? PREP : IDLE;
      PREP: begin
        busy        = 1'b1;
        w_state_nxt = (w_is_div && (r_b == '0)) ? DONE : CALC;
      end
      CALC: begin
        busy = 1'b1;
        if (r_cnt == CNT_W'(WIDTH - 1)) w_state_nxt = FIX;
      end
      FIX: begin
        busy        = 1'b1;
        w_state_nxt = DONE;
      end
      DONE: begin
        done        = 1'b1;
        w_state_nxt = start ? PREP : IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state    <= IDLE;
      r_op       <= MD_MULT;
      r_a        <= '0;
      r_b        <= '0;
      r_m        <= '0;
      r_acc      <= '0;
      r_cnt      <= '0;
      r_neg_res  <= 1'b0;
      r_neg_rem  <= 1'b0;
      r_div_zero <= 1'b0;
      r_hi       <= '0;
      r_lo       <= '0;
    end else begin
      r_state <= w_state_nxt;
      case (r_state)
        IDLE, DONE: begin
          if (start) begin
            r_op       <= md_op_e'(op);
            r_a        <= a;
            r_b        <= b;
            r_div_zero <= 1'b0;
          end
        end
        PREP: begin
          r_cnt     <= '0;
          r_neg_res <= w_signed & (r_a[WIDTH-1] ^ r_b[WIDTH-1]);
          r_neg_rem <= w_signed & r_a[WIDTH-1];
          r_m       <= w_is_div ? w_mag_b : w_mag_a;
          r_acc     <= {{WIDTH{1'b0}}, (w_is_div ? w_mag_a : w_mag_b)};
          if (w_is_div && (r_b == '0)) r_div_zero <= 1'b1;
        end
        CALC: begin
          r_acc <= w_is_div ? w_acc_div : w_acc_mul;
          r_cnt <= r_cnt + CNT_W'(1);
        end
        FIX: begin
          if (w_is_div) begin
            r_hi <= w_rem;
            r_lo <= w_quo;
          end else begin
            {r_hi, r_lo} <= w_prod;
          end
        end
        default: ;
      endcase
    end
  end

  assign div_zero = r_div_zero;
  assign hi       = r_hi;
  assign lo       = r_lo;

endmodule

// File: tb/tb_muldiv_seq.sv
// Scoreboard bench for muldiv_seq: expected HI/LO/div_zero queued at issue, checked on done.
module tb_muldiv_seq;
  import muldiv_pkg::*;

  localparam int W = 32;

  logic         clk, reset, start;
  logic [1:0]   op;
  logic [W-1:0] a, b, hi, lo;
  logic         busy, done, div_zero;

  int           n_chk = 0, n_pass = 0, cyc = 0;
  logic [64:0]  sb[$];
  logic [64:0]  sb_e;
  logic [W-1:0] p_hi = '0, p_lo = '0;
  int           t1, t2, t;

  muldiv_seq #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .done(done), .div_zero(div_zero), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Independent reference: 64-bit native arithmetic.
  function automatic logic [63:0] model(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    longint sx = longint'($signed(x));
    longint sy = longint'($signed(y));
    longint ux = longint'({32'b0, x});
    longint uy = longint'({32'b0, y});
    case (o)
      2'b00:   return 64'(sx * sy);
      2'b01:   return 64'(ux * uy);
      2'b10:   return {32'(sx % sy), 32'(sx / sy)};
      default: return {32'(ux % uy), 32'(ux / uy)};
    endcase
  endfunction

  // Result checks happen whenever done pulses.
  always @(negedge clk) begin
    if (reset && done) begin
      if (sb.size() == 0) chk("sb_underflow", 64'(1), 64'(0));
      else begin
        sb_e = sb.pop_front();
        chk("hi", 64'(hi), 64'(sb_e[63:32]));
        chk("lo", 64'(lo), 64'(sb_e[31:0]));
        chk("div_zero", 64'(div_zero), 64'(sb_e[64]));
      end
    end
  end

  // Called at a negedge; returns at the negedge of the done cycle.
  task automatic do_op(input logic [1:0] o, input logic [W-1:0] ia, input logic [W-1:0] ib,
                       input logic [63:0] exp, input logic edz, input int lat, input int poke,
                       output int tdone);
    int n;
    start = 1'b1; op = o; a = ia; b = ib;
    sb.push_back({edz, exp});
    @(posedge clk);
    @(negedge clk);
    start = 1'b0; a = ~ia; b = '0; op = ~o;
    chk("dz_clr", 64'(div_zero), 64'(0));
    chk("busy_run", 64'(busy), 64'(1));
    n = 0;
    while (!done && n < 100) begin
      if (poke != 0 && n == poke - 1) begin
        start = 1'b1; op = 2'b00; a = 32'd1; b = 32'd1;
      end
      @(posedge clk);
      n++;
      @(negedge clk);
      if (poke != 0 && n == poke) begin
        start = 1'b0;
        chk("busy_ign", 64'(busy), 64'(1));
        chk("hi_stable", 64'(hi), 64'(p_hi));
        chk("lo_stable", 64'(lo), 64'(p_lo));
      end
    end
    chk("latency", 64'(n), 64'(lat));
    chk("busy_done", 64'(busy), 64'(0));
    if (!edz) begin
      p_hi = exp[63:32];
      p_lo = exp[31:0];
    end
    tdone = cyc;
  endtask

  task automatic idle();
    @(posedge clk);
    @(negedge clk);
    chk("done_pulse", 64'(done), 64'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: run did not finish");
    $fatal(1);
  end

  initial begin
    logic [W-1:0] mneg;
    clk = 1'b0; reset = 1'b0; start = 1'b0; op = '0; a = '0; b = '0;
    mneg = 32'(md_most_neg(W));
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_done", 64'(done), 64'(0));
    chk("rst_dz", 64'(div_zero), 64'(0));
    chk("rst_hi", 64'(hi), 64'(0));
    chk("rst_lo", 64'(lo), 64'(0));
    reset = 1'b1;
    @(negedge clk);

    do_op(MD_MULT, 32'h7, 32'hFFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFEB, 1'b0, W + 2, 0, t); idle();
    do_op(MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 1'b0, W + 2, 10, t); idle();
    do_op(MD_DIV, 32'hFFFF_FFF9, 32'd2, 64'hFFFF_FFFF_FFFF_FFFD, 1'b0, W + 2, 0, t); idle();
    do_op(MD_DIV, mneg, 32'hFFFF_FFFF, {32'h0, mneg}, 1'b0, W + 2, 0, t); idle();

    do_op(MD_DIVU, 32'd100, 32'd0, {p_hi, p_lo}, 1'b1, 1, 0, t); idle();
    chk("dz_sticky", 64'(div_zero), 64'(1));

    // Abort a divide with reset at edge 12.
    start = 1'b1; op = MD_DIVU; a = 32'd100; b = 32'd7;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (11) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("abort_busy", 64'(busy), 64'(0));
    chk("abort_done", 64'(done), 64'(0));
    chk("abort_hi", 64'(hi), 64'(0));
    chk("abort_lo", 64'(lo), 64'(0));
    reset = 1'b1;
    p_hi = '0; p_lo = '0;
    @(negedge clk);

    do_op(MD_DIVU, 32'd100, 32'd7, {32'd2, 32'd14}, 1'b0, W + 2, 0, t1);
    do_op(MD_MULT, 32'd3, 32'd4, 64'd12, 1'b0, W + 2, 0, t2); idle();
    chk("b2b_gap", 64'(t2 - t1), 64'(W + 3));

    for (int i = 0; i < 8; i++) begin
      logic [1:0]   ro;
      logic [W-1:0] rx, ry;
      ro = 2'($urandom_range(0, 3));
      rx = $urandom;
      ry = (i < 4) ? 32'($urandom_range(1, 20)) : $urandom;
      if (i[0]) ry = -ry;
      if (ry == '0) ry = 32'd1;
      do_op(ro, rx, ry, model(ro, rx, ry), 1'b0, W + 2, 0, t); idle();
    end

    chk("sb_empty", 64'(sb.size()), 64'(0));
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/muldiv_seq.md
Name: muldiv_seq

Overview:
- Parametrised iterative multiply/divide unit with internal HI/LO result registers.
- Supersedes the combinational mult/div pair and the external HI/LO registers in the multicycle CPU datapath.
- Handles signed and unsigned MULT/DIV over WIDTH-bit operands using a start/busy/done handshake.
- The control unit waits on done before it issues MFHI/MFLO.

Parameters:
- WIDTH, 32: operand width. HI and LO are each WIDTH bits. Must be at least 4.
- CNT_W, $clog2(WIDTH+1): width of the iteration counter. Derived; do not override.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-low reset.
- start  in  1  request pulse. Sampled only when busy=0.
- op  in  2  operation code: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- a  in  WIDTH  operand A (multiplicand / dividend).
- b  in  WIDTH  operand B (multiplier / divisor).
- busy  out  1  high in states PREP, CALC and FIX.
- done  out  1  one-cycle pulse. HI and LO are valid when it is high.
- div_zero  out  1  set when a DIV or DIVU has a zero divisor. Sticky until the next accepted start.
- hi  out  WIDTH  MULT: product upper half. DIV: remainder.
- lo  out  WIDTH  MULT: product lower half. DIV: quotient.

Behaviour:
- Reset (reset=0 at a rising edge):
  - state=IDLE, hi=0, lo=0, done=0, div_zero=0, counter=0.
  - Reset during any state aborts the operation with no partial writeback.
- States are IDLE, PREP, CALC, FIX, DONE.
- Start acceptance:
  - Start is accepted in IDLE or DONE (back-to-back operation is allowed).
  - Start while busy=1 is ignored; no queueing.
- Capture at the accepting edge (call it edge 0):
  - op, a and b are latched; later changes on the inputs have no effect.
  - div_zero is cleared; state goes to PREP.
- PREP (edge 1):
  - For signed ops, operands are converted to magnitudes, and the result sign and remainder sign are recorded.
  - For DIV/DIVU with b=0: go straight to DONE with div_zero=1. hi and lo keep their previous values, and done is high after edge 1.
  - Otherwise the counter is cleared and state goes to CALC.
- CALC:
  - Runs exactly WIDTH iterations, one per edge (edges 2..WIDTH+1).
  - MULT uses shift-add over a 2*WIDTH accumulator.
  - DIV uses restoring division, one quotient bit per cycle.
  - The last iteration moves state to FIX.
- FIX (edge WIDTH+2):
  - Conditional two's-complement negation is applied to the result.
  - Signed MULT: the product is negated if the operand signs differ.
  - Signed DIV: the quotient is negated if the operand signs differ, and the remainder takes the dividend's sign (quotient truncates toward zero).
  - hi and lo are loaded, done=1, and state goes to DONE.
- DONE:
  - Lasts one cycle; done=1 and busy=0.
  - Without a start, the next edge goes to IDLE with done=0.
- Latency: done is high after edge WIDTH+2, i.e. after edge 34 for WIDTH=32.
- Signed divide overflow: DIV of the most-negative value by -1 gives lo = the most-negative value (wraps) and hi=0. No flag is raised.
- Unsigned ops skip all sign handling.
- hi and lo change only at the FIX→DONE edge or at reset. They are stable at all other times, including while busy.

Decomposition:
- Package muldiv_pkg holds:
  - the op encodings MD_MULT, MD_MULTU, MD_DIV, MD_DIVU;
  - the state enum (IDLE, PREP, CALC, FIX, DONE);
  - a helper constant for the most-negative WIDTH value.
- Sub-module muldiv_negate: combinational, parametrised WIDTH. Returns the input, or its two's complement when a control bit is set.
  - PREP uses it for operand magnitudes.
  - FIX uses it for result correction.
- The FSM, counter, accumulator and HI/LO registers stay in muldiv_seq.

Test Plan:
- MULT, a=0x00000007, b=0xFFFFFFFD → after edge 34: done=1, hi=0xFFFFFFFF, lo=0xFFFFFFEB, busy low in the same cycle.
- MULTU, a=b=0xFFFFFFFF → hi=0xFFFFFFFE, lo=0x00000001. A start pulsed at edge 10 is ignored and the result is unchanged.
- DIV, a=0xFFFFFFF9 (-7), b=2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF.
  - Then DIV of 0x80000000 by 0xFFFFFFFF → lo=0x80000000, hi=0.
- Prime hi/lo with a valid op, then DIVU a=100, b=0 → done after edge 1, div_zero=1, hi/lo unchanged.
  - Next accepted start clears div_zero.
- Start DIVU 100/7 and assert reset=0 at edge 12 → busy=0, hi=lo=0, done=0.
  - A following DIVU 100/7 gives lo=14, hi=2.
- Back-to-back: assert start during the DONE cycle with MULT 3×4 → accepted. The second done arrives 35 edges after the first, with lo=12 and hi=0.
